// File: rtl/shift_core_reg.sv
// shift_core_reg: registered 8-bit barrel shifter for the ALU shift path.
// Left shift, or right shift selected by MODE (pass / logical / arithmetic /
// rotate), built from 1-bit 2:1 mux cells in log2(WIDTH) barrel layers. The
// result and its valid flag are registered; nothing reaches OUTPUT without
// passing through a flop.

// 1-bit 2:1 mux cell used to build every barrel layer and the final select.
module shift_core_reg_mux2 (
    input  logic sel,
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = sel ? b : a;
endmodule

module shift_core_reg #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic [1:0]       MODE,
    input  logic             IN_VALID,
    output logic [WIDTH-1:0] OUTPUT,
    output logic             OUT_VALID
);

    // Only WIDTH=8 is supported, so the amount field sh is DATA2[2:0].
    localparam int STAGES = $clog2(WIDTH);

    typedef enum logic [1:0] {
        MODE_PASS  = 2'b00,
        MODE_LOG   = 2'b01,
        MODE_ARITH = 2'b10,
        MODE_ROT   = 2'b11
    } mode_e;

    // ------------------------------------------------------------------
    // Operand decode
    // ------------------------------------------------------------------
    logic [STAGES-1:0]        sh;
    logic                     ge8;
    logic                     dir_right;
    mode_e                    mode;
    logic                     is_rot;
    logic                     right_fill;
    logic signed [WIDTH-1:0]  data1_s;

    assign sh         = DATA2[STAGES-1:0];
    assign ge8        = |DATA2[WIDTH-2:STAGES];
    assign dir_right  = DATA2[WIDTH-1];
    assign mode       = mode_e'(MODE);
    assign is_rot     = (mode == MODE_ROT);
    // Bits shifted in at the top: sign bit for arithmetic, zero otherwise.
    // Rotate replaces this with the wrapped bit inside the layer.
    assign right_fill = (mode == MODE_ARITH) & DATA1[WIDTH-1];
    assign data1_s    = DATA1;

    // Final out-of-range / pass handling applied after the barrel.
    // Pass returns the operand untouched; rotate ignores the >=8 part of the
    // amount (mod-8 behaviour falls out of using sh only); everything else
    // saturates to zero, or to the sign for arithmetic right shifts.
    function automatic logic [WIDTH-1:0] apply_range(
        input logic                    right,
        input mode_e                   m,
        input logic                    big,
        input logic [WIDTH-1:0]        shifted,
        input logic signed [WIDTH-1:0] src
    );
        logic [WIDTH-1:0] res;
        res = shifted;
        if (right) begin
            case (m)
                MODE_PASS:  res = $unsigned(src);
                MODE_LOG:   if (big) res = '0;
                MODE_ARITH: if (big) res = $unsigned(src >>> (WIDTH - 1));
                MODE_ROT:   res = shifted;
                default:    res = shifted;
            endcase
        end else if (big) begin
            res = '0;
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Right barrel: layer k moves bits down by 2^k when sh[k] is set
    // ------------------------------------------------------------------
    logic [STAGES:0][WIDTH-1:0] rs;
    assign rs[0] = DATA1;

    for (genvar k = 0; k < STAGES; k++) begin : g_rlayer
        for (genvar i = 0; i < WIDTH; i++) begin : g_rbit
            logic src_bit;
            if (i + (1 << k) < WIDTH) begin : g_inside
                assign src_bit = rs[k][i + (1 << k)];
            end else begin : g_edge
                // Bits entering from above the MSB: wrapped for rotate,
                // fill value otherwise.
                shift_core_reg_mux2 u_wrap (
                    .sel (is_rot),
                    .a   (right_fill),
                    .b   (rs[k][i + (1 << k) - WIDTH]),
                    .y   (src_bit)
                );
            end
            shift_core_reg_mux2 u_cell (
                .sel (sh[k]),
                .a   (rs[k][i]),
                .b   (src_bit),
                .y   (rs[k+1][i])
            );
        end
    end

    // ------------------------------------------------------------------
    // Left barrel: layer k moves bits up by 2^k, zero fill at the bottom
    // ------------------------------------------------------------------
    logic [STAGES:0][WIDTH-1:0] ls;
    assign ls[0] = DATA1;

    for (genvar k = 0; k < STAGES; k++) begin : g_llayer
        for (genvar i = 0; i < WIDTH; i++) begin : g_lbit
            logic src_bit;
            if (i >= (1 << k)) begin : g_inside
                assign src_bit = ls[k][i - (1 << k)];
            end else begin : g_edge
                assign src_bit = 1'b0;
            end
            shift_core_reg_mux2 u_cell (
                .sel (sh[k]),
                .a   (ls[k][i]),
                .b   (src_bit),
                .y   (ls[k+1][i])
            );
        end
    end

    // ------------------------------------------------------------------
    // Left/right select
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] dir_sel;

    for (genvar i = 0; i < WIDTH; i++) begin : g_dirsel
        shift_core_reg_mux2 u_sel (
            .sel (dir_right),
            .a   (ls[STAGES][i]),
            .b   (rs[STAGES][i]),
            .y   (dir_sel[i])
        );
    end

    logic [WIDTH-1:0] shift_result;
    assign shift_result = apply_range(dir_right, mode, ge8, dir_sel, data1_s);

    // ------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] out_d, out_q;
    logic             out_vld_d, out_vld_q;

    // Next-state: capture on IN_VALID, otherwise hold the data and drop valid.
    always_comb begin
        out_d     = out_q;
        out_vld_d = IN_VALID;
        if (IN_VALID) begin
            out_d = shift_result;
        end
    end

    // Result and valid flops; reset clears both immediately.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign OUTPUT    = out_q;
    assign OUT_VALID = out_vld_q;

endmodule

// File: tb/tb_shift_core_reg.sv
// Testbench for shift_core_reg: directed table, hand sequences for reset and
// throughput, and random traffic against an arithmetic reference model.
module tb_shift_core_reg;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] DATA1;
    logic [7:0] DATA2;
    logic [1:0] MODE;
    logic       IN_VALID;
    logic [7:0] OUTPUT;
    logic       OUT_VALID;

    int checks   = 0;
    int failures = 0;

    shift_core_reg #(.WIDTH(8)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .DATA1     (DATA1),
        .DATA2     (DATA2),
        .MODE      (MODE),
        .IN_VALID  (IN_VALID),
        .OUTPUT    (OUTPUT),
        .OUT_VALID (OUT_VALID)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] d1;
        logic [7:0] d2;
        logic [1:0] mode;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[16];

    // Reference: shift amount is the whole 7-bit field, computed with plain
    // operators on integers.
    function automatic logic [7:0] ref_shift(input logic [7:0] d1,
                                             input logic [7:0] d2,
                                             input logic [1:0] m);
        int amt;
        logic signed [7:0] s;
        logic [15:0] dbl;
        amt = int'(d2[6:0]);
        if (!d2[7]) return (amt >= 8) ? 8'h00 : 8'(d1 << amt);
        case (m)
            2'b00: return d1;
            2'b01: return (amt >= 8) ? 8'h00 : (d1 >> amt);
            2'b10: begin
                s = d1;
                return 8'(s >>> amt);
            end
            default: begin
                dbl = {d1, d1};
                dbl = dbl >> (amt % 8);
                return dbl[7:0];
            end
        endcase
    endfunction

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] d1, input logic [7:0] d2,
                         input logic [1:0] m, input logic v);
        DATA1 = d1; DATA2 = d2; MODE = m; IN_VALID = v;
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    logic [7:0] exp_out;
    logic       exp_vld;

    initial begin
        vecs[0]  = '{8'hAA, 8'h81, 2'b01, 8'h55};
        vecs[1]  = '{8'hFF, 8'hBF, 2'b01, 8'h00};
        vecs[2]  = '{8'hFF, 8'hBF, 2'b10, 8'hFF};
        vecs[3]  = '{8'hFF, 8'hBF, 2'b11, 8'hFF};
        vecs[4]  = '{8'h81, 8'h82, 2'b10, 8'hE0};
        vecs[5]  = '{8'h41, 8'h82, 2'b10, 8'h10};
        vecs[6]  = '{8'h11, 8'h85, 2'b11, 8'h88};
        vecs[7]  = '{8'h0F, 8'h03, 2'b10, 8'h78};
        vecs[8]  = '{8'h5A, 8'h80, 2'b00, 8'h5A};
        vecs[9]  = '{8'h5A, 8'hFF, 2'b00, 8'h5A};
        vecs[10] = '{8'hC3, 8'h08, 2'b11, 8'h00};
        vecs[11] = '{8'hC3, 8'h00, 2'b10, 8'hC3};
        vecs[12] = '{8'h7F, 8'hBF, 2'b10, 8'h00};
        vecs[13] = '{8'h96, 8'h87, 2'b01, 8'h01};
        vecs[14] = '{8'h97, 8'h07, 2'b00, 8'h80};
        vecs[15] = '{8'hC3, 8'h80, 2'b11, 8'hC3};

        RESET = 1'b0;
        drive(8'h00, 8'h00, 2'b00, 1'b0);
        #2;
        chk8("reset_out", OUTPUT, 8'h00);
        chk1("reset_vld", OUT_VALID, 1'b0);
        #21 RESET = 1'b1;
        step();
        chk8("idle_after_reset_out", OUTPUT, 8'h00);
        chk1("idle_after_reset_vld", OUT_VALID, 1'b0);

        // Table, back-to-back captures.
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].d1, vecs[i].d2, vecs[i].mode, 1'b1);
            step();
            chk8($sformatf("vec%0d_out", i), OUTPUT, vecs[i].exp);
            chk1($sformatf("vec%0d_vld", i), OUT_VALID, 1'b1);
        end

        // Hold: no capture keeps data, drops valid.
        drive(8'h12, 8'h01, 2'b00, 1'b0);
        step();
        chk8("hold_out", OUTPUT, 8'hC3);
        chk1("hold_vld", OUT_VALID, 1'b0);

        // Left then four right cases on consecutive cycles.
        drive(8'h0F, 8'h03, 2'b00, 1'b1); step();
        chk8("seq_left", OUTPUT, 8'h78);
        drive(8'hAA, 8'h81, 2'b01, 1'b1); step();
        chk8("seq_log", OUTPUT, 8'h55);   chk1("seq_log_vld", OUT_VALID, 1'b1);
        drive(8'h81, 8'h82, 2'b10, 1'b1); step();
        chk8("seq_arith", OUTPUT, 8'hE0); chk1("seq_arith_vld", OUT_VALID, 1'b1);
        drive(8'h11, 8'h85, 2'b11, 1'b1); step();
        chk8("seq_rot", OUTPUT, 8'h88);   chk1("seq_rot_vld", OUT_VALID, 1'b1);
        drive(8'h5A, 8'hFF, 2'b00, 1'b1); step();
        chk8("seq_pass", OUTPUT, 8'h5A);  chk1("seq_pass_vld", OUT_VALID, 1'b1);

        // Reset asserted mid-run with a capture pending.
        drive(8'hFF, 8'h01, 2'b00, 1'b1);
        #3 RESET = 1'b0;
        #1;
        chk8("midreset_out", OUTPUT, 8'h00);
        chk1("midreset_vld", OUT_VALID, 1'b0);
        step();
        chk8("midreset_held_out", OUTPUT, 8'h00);
        drive(8'h00, 8'h00, 2'b00, 1'b0);
        #3 RESET = 1'b1;
        step();
        chk8("release_out", OUTPUT, 8'h00);
        chk1("release_vld", OUT_VALID, 1'b0);

        // Random traffic against the reference model.
        exp_out = 8'h00;
        for (int n = 0; n < 300; n++) begin
            drive(8'($urandom), 8'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0));
            if (IN_VALID) exp_out = ref_shift(DATA1, DATA2, MODE);
            exp_vld = IN_VALID;
            step();
            chk8($sformatf("rand%0d_out", n), OUTPUT, exp_out);
            chk1($sformatf("rand%0d_vld", n), OUT_VALID, exp_vld);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
